fp32_max_tracker: RTL and testbench
===================================

// Module: fp32_max_tracker
// PURPOSE
// - Streaming consumer of the FP32 greater-than compare: accepts a frame of IEEE-754 single-precision values
//   and returns the frame maximum, its index and the element count.
// - Sits between a neuron-value producer (membrane potentials / scores) and the winner-take-all / readout logic.
// - Handshake on both sides; one element per cycle sustained; result held until consumed.
// PARAMETERS
// - IDX_W    8    width of element index and count; max frame length = 2**IDX_W
// PORTS
// - CLK        in   1      system clock, rising edge
// - RESET      in   1      asynchronous, active-low reset
// - in_valid   in   1      in_data/in_last valid
// - in_ready   out  1      block can accept an element this cycle
// - in_data    in   32     FP32 element
// - in_last    in   1      final element of frame
// - out_valid  out  1      result valid, held until out_ready
// - out_ready  in   1      downstream accepts result
// - out_max    out  32     maximum (FP32 bit pattern)
// - out_index  out  IDX_W  index of maximum (first occurrence)
// - out_count  out  IDX_W  elements in frame minus 1 (0 => 1 element)
// - out_nan    out  1      at least one NaN element was dropped
// - out_trunc  out  1      frame force-closed at 2**IDX_W elements without in_last
// BEHAVIOUR
// - Reset (async assert, sync deassert by CLK): state IDLE; in_ready=1, out_valid=0; out_max, out_index,
//   out_count, out_nan, out_trunc all 0; running registers cleared.
// - Transfer on either side only when valid && ready in same cycle.
// - FSM: IDLE -> ACCUM on first accepted element (loads max=data, index=0, count=0);
//   ACCUM: each accepted element increments count; if data > max (strict) then max=data, index=count+1.
//   Any accepted element with in_last=1, or the element at count=2**IDX_W-1, -> HOLD.
//   HOLD: in_ready=0, out_valid=1; on out_ready -> IDLE, in_ready=1 next cycle.
//   1-element frame: first element with in_last=1 goes IDLE -> HOLD directly.
// - Latency: out_valid asserts the cycle after the last element is accepted; no back-to-back frame overlap
//   (one idle-accept bubble per frame is allowed: in_ready low during HOLD).
// - Compare rules (a > b): sign/magnitude ordering on FP32; +0 and -0 equal; ties keep earlier index;
//   +Inf/-Inf ordered normally; denormals compared by bit magnitude.
// - NaN (exp=0xFF, mantissa!=0): accepted, counted, never becomes max, sets out_nan. If first element is NaN,
//   max is seeded from the first non-NaN; all-NaN frame -> out_max=32'h7FC00000, out_index=0.
// - out_trunc=1 only when HOLD entered via count limit with in_last=0; the next element starts a new frame.
// - Output fields stable throughout HOLD; updated only on IDLE/ACCUM->HOLD transition.
// - in_valid ignored while in_ready=0; no data loss under any out_ready pattern.
// - Reset mid-frame: frame discarded, no output produced.
// STRUCTURE
// - Shared package: FP32 field constants (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23),
//   QNAN constant 32'h7FC00000, FSM state encoding (IDLE, ACCUM, HOLD).
// - One sub-module: fp32_gt_cmp (combinational, a,b -> a_gt_b, a_is_nan), instantiated once against
//   the running maximum; FSM, counters and output registers in this module.
// TESTING
// - Frame {1.0(3F800000), 10.0(41200000), -5.0(C0A00000)} last on 3rd, out_ready=1 -> max=41200000,
//   index=1, count=2, nan=0, trunc=0, out_valid one cycle after last accept.
// - Ties and zeros: {80000000, 00000000, 41200000, 41200000} -> max=41200000, index=2; {80000000,00000000} -> index=0.
// - NaN: {7FC00001, C0A00000, 7F800001} -> max=C0A00000, index=1, nan=1; all-NaN frame -> max=7FC00000, index=0, nan=1.
// - Backpressure: hold out_ready=0 10 cycles with in_valid=1 -> in_ready=0, outputs stable; release ->
//   next frame accepted, results correct for both frames.
// - Truncation (IDX_W=2): 5 elements, no in_last -> first result count=3, trunc=1; 5th element forms new frame.
// - Assert RESET mid-frame and during HOLD -> out_valid=0, in_ready=1 immediately; next frame unaffected.

Source files
------------

// File: rtl/fp32_max_tracker_pkg.sv
// Shared FP32 field layout, canonical quiet NaN and tracker FSM encoding.
// Imported by the comparator and the max tracker.
package fp32_max_tracker_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

endpackage

// File: rtl/fp32_gt_cmp.sv
// Combinational FP32 strict greater-than; b is expected to be a non-NaN maximum.
// Zeros of either sign compare equal; a NaN a never wins.
module fp32_gt_cmp
    import fp32_max_tracker_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_gt_b,
    output logic        a_is_nan
);

    logic [EXP_MSB:EXP_LSB] a_exp;
    logic [MAN_W-1:0]       a_man;
    logic [EXP_MSB:0]       a_mag;
    logic [EXP_MSB:0]       b_mag;
    logic                   a_sign;
    logic                   b_sign;

    assign a_exp    = a[EXP_MSB:EXP_LSB];
    assign a_man    = a[MAN_W-1:0];
    assign a_mag    = a[EXP_MSB:0];
    assign b_mag    = b[EXP_MSB:0];
    assign a_sign   = a[SIGN_BIT];
    assign b_sign   = b[SIGN_BIT];
    assign a_is_nan = (&a_exp) && (|a_man);

    always_comb begin
        a_gt_b = 1'b0;
        case ({a_sign, b_sign})
            2'b00:   a_gt_b = a_mag > b_mag;
            // positive beats negative unless both are zeros
            2'b01:   a_gt_b = |{a_mag, b_mag};
            2'b11:   a_gt_b = a_mag < b_mag;
            default: a_gt_b = 1'b0;
        endcase
        if (a_is_nan) begin
            a_gt_b = 1'b0;
        end
    end

endmodule

// File: rtl/fp32_max_tracker.sv
// Streaming FP32 frame maximum with index, count, NaN and truncation flags.
// Result is held in HOLD until the downstream side accepts it.
module fp32_max_tracker
    import fp32_max_tracker_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_max,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_count,
    output logic             out_nan,
    output logic             out_trunc
);

    localparam logic [IDX_W-1:0] LAST_POS = '1;

    state_t state_q, state_d;

    logic [31:0]      max_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] cnt_q;
    logic             nan_q;
    logic             have_q;

    logic             fresh;
    logic [31:0]      base_max;
    logic [IDX_W-1:0] base_idx;
    logic             base_have;
    logic             base_nan;
    logic [IDX_W-1:0] pos;

    logic             gt;
    logic             is_nan;
    logic             take;
    logic             accept;
    logic             at_limit;
    logic             closing;
    logic [31:0]      nxt_max;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_nan;

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    // An element arriving in IDLE starts from an empty frame.
    always_comb begin
        fresh     = (state_q == IDLE);
        base_max  = fresh ? QNAN : max_q;
        base_idx  = fresh ? '0 : idx_q;
        base_have = fresh ? 1'b0 : have_q;
        base_nan  = fresh ? 1'b0 : nan_q;
        pos       = fresh ? '0 : cnt_q + 1'b1;
    end

    fp32_gt_cmp u_cmp (
        .a        (in_data),
        .b        (base_max),
        .a_gt_b   (gt),
        .a_is_nan (is_nan)
    );

    assign take     = !is_nan && (!base_have || gt);
    assign nxt_max  = take ? in_data : base_max;
    assign nxt_idx  = take ? pos : base_idx;
    assign nxt_nan  = base_nan || is_nan;
    assign at_limit = (pos == LAST_POS);
    assign closing  = accept && (in_last || at_limit);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (closing) begin
                    state_d = HOLD;
                end else if (accept) begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            max_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            nan_q  <= 1'b0;
            have_q <= 1'b0;
        end else if (accept) begin
            max_q  <= nxt_max;
            idx_q  <= nxt_idx;
            cnt_q  <= pos;
            nan_q  <= nxt_nan;
            have_q <= base_have || take;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_max   <= '0;
            out_index <= '0;
            out_count <= '0;
            out_nan   <= 1'b0;
            out_trunc <= 1'b0;
        end else if (closing) begin
            out_max   <= nxt_max;
            out_index <= nxt_idx;
            out_count <= pos;
            out_nan   <= nxt_nan;
            out_trunc <= at_limit && !in_last;
        end
    end

endmodule

// File: tb/tb_fp32_max_tracker.sv
// Bench for fp32_max_tracker: directed literal frames plus randomized
// streams checked every cycle against a value-level frame model.
module tb_fp32_max_tracker;

    localparam int IDX_W  = 2;
    localparam int MAXLEN = 1 << IDX_W;

    logic             CLK;
    logic             RESET;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_max;
    logic [IDX_W-1:0] out_index;
    logic [IDX_W-1:0] out_count;
    logic             out_nan;
    logic             out_trunc;

    int checks = 0;
    int errors = 0;
    bit bp_rand = 0;

    typedef struct {
        logic [31:0] mx;
        int          idx;
        int          cnt;
        bit          nan;
        bit          trunc;
    } res_t;

    logic [31:0] frame[$];
    bit          pending = 0;
    res_t        exp_r;

    fp32_max_tracker #(.IDX_W(IDX_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_index (out_index),
        .out_count (out_count),
        .out_nan   (out_nan),
        .out_trunc (out_trunc)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_nan(logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    // Signed ordering key: -0 and +0 both map to 0.
    function automatic longint key(logic [31:0] x);
        longint m;
        m = longint'({33'd0, x[30:0]});
        return x[31] ? -m : m;
    endfunction

    function automatic res_t reduce(bit last);
        res_t r;
        bit   have;
        have    = 0;
        r.mx    = 32'h7FC00000;
        r.idx   = 0;
        r.nan   = 0;
        r.cnt   = frame.size() - 1;
        r.trunc = !last;
        foreach (frame[i]) begin
            if (is_nan(frame[i])) r.nan = 1;
            else if (!have || key(frame[i]) > key(r.mx)) begin
                r.mx  = frame[i];
                r.idx = i;
                have  = 1;
            end
        end
        return r;
    endfunction

    // Cycle checker and model update, away from the active edge.
    initial forever begin
        @(negedge CLK);
        if (!RESET) begin
            frame.delete();
            pending = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_max", out_max, 0);
            chk("rst_out_index", out_index, 0);
            chk("rst_out_count", out_count, 0);
            chk("rst_flags", {out_nan, out_trunc}, 0);
        end else begin
            chk("out_valid", out_valid, pending);
            chk("in_ready", in_ready, !pending);
            if (pending) begin
                chk("out_max", out_max, exp_r.mx);
                chk("out_index", out_index, exp_r.idx);
                chk("out_count", out_count, exp_r.cnt);
                chk("out_nan", out_nan, exp_r.nan);
                chk("out_trunc", out_trunc, exp_r.trunc);
                if (out_ready) pending = 0;
            end else if (in_valid) begin
                frame.push_back(in_data);
                if (in_last || frame.size() == MAXLEN) begin
                    exp_r   = reduce(in_last);
                    pending = 1;
                    frame.delete();
                end
            end
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        if (bp_rand) out_ready = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(logic [31:0] d, bit last);
        int w;
        w        = 0;
        in_valid = 1;
        in_data  = d;
        in_last  = last;
        @(negedge CLK);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge CLK);
        end
        chk("send_accept", in_ready, 1);
        @(posedge CLK);
        #1;
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic expect_res(logic [31:0] mx, int idx, int cnt, bit nan, bit trunc);
        @(negedge CLK);
        chk("lit_valid", out_valid, 1);
        chk("lit_max", out_max, mx);
        chk("lit_index", out_index, idx);
        chk("lit_count", out_count, cnt);
        chk("lit_nan", out_nan, nan);
        chk("lit_trunc", out_trunc, trunc);
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 17))
            0:  return 32'h00000000;
            1:  return 32'h80000000;
            2:  return 32'h3F800000;
            3:  return 32'hBF800000;
            4:  return 32'h41200000;
            5:  return 32'hC0A00000;
            6:  return 32'h7F800000;
            7:  return 32'hFF800000;
            8:  return 32'h7FC00000;
            9:  return 32'h7F800001;
            10: return 32'hFFC00001;
            11: return 32'h00000001;
            12: return 32'h80000005;
            13: return 32'h007FFFFF;
            14: return 32'h40000000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        RESET     = 0;
        in_valid  = 0;
        in_data   = 0;
        in_last   = 0;
        out_ready = 1;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1;

        send(32'h3F800000, 0);
        send(32'h41200000, 0);
        send(32'hC0A00000, 1);
        expect_res(32'h41200000, 1, 2, 0, 0);

        send(32'h80000000, 0);
        send(32'h00000000, 0);
        send(32'h41200000, 0);
        send(32'h41200000, 1);
        expect_res(32'h41200000, 2, 3, 0, 0);

        send(32'h80000000, 0);
        send(32'h00000000, 1);
        expect_res(32'h80000000, 0, 1, 0, 0);

        send(32'h7FC00001, 0);
        send(32'hC0A00000, 0);
        send(32'h7F800001, 1);
        expect_res(32'hC0A00000, 1, 2, 1, 0);

        send(32'h7F800001, 0);
        send(32'hFFC00000, 1);
        expect_res(32'h7FC00000, 0, 1, 1, 0);

        send(32'h3F800000, 0);
        send(32'h40000000, 0);
        send(32'h40400000, 0);
        send(32'h3F000000, 0);
        expect_res(32'h40400000, 2, 3, 0, 1);
        send(32'hC0000000, 1);
        expect_res(32'hC0000000, 0, 0, 0, 0);

        out_ready = 0;
        send(32'h40000000, 1);
        expect_res(32'h40000000, 0, 0, 0, 0);
        in_valid = 1;
        in_data  = 32'h41000000;
        in_last  = 1;
        repeat (10) begin
            @(negedge CLK);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_max", out_max, 32'h40000000);
        end
        @(posedge CLK);
        #1;
        out_ready = 1;
        send(32'h41000000, 1);
        expect_res(32'h41000000, 0, 0, 0, 0);

        send(32'h3F800000, 0);
        send(32'h40000000, 0);
        RESET = 0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_ready", in_ready, 1);
        @(posedge CLK);
        #1;
        RESET = 1;
        send(32'hC0A00000, 0);
        send(32'hBF800000, 1);
        expect_res(32'hBF800000, 1, 1, 0, 0);

        out_ready = 0;
        send(32'h42000000, 1);
        expect_res(32'h42000000, 0, 0, 0, 0);
        RESET = 0;
        #1;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_ready", in_ready, 1);
        @(posedge CLK);
        #1;
        RESET     = 1;
        out_ready = 1;
        send(32'h3F800000, 1);
        expect_res(32'h3F800000, 0, 0, 0, 0);

        bp_rand = 1;
        for (int f = 0; f < 300; f++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge CLK);
                    #1;
                end
                send(rand_val(), (i == n - 1) && ($urandom_range(0, 4) != 0));
            end
        end

        bp_rand   = 0;
        out_ready = 1;
        in_valid  = 0;
        repeat (6) @(posedge CLK);
        #1;
        chk("drain_valid", out_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
